// File: rtl/string_batch_pkg.sv
// Shared types and constants for the host batch sequencer and its response serializer.
package string_batch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  localparam logic [7:0] STATUS_NO_MATCH = 8'h00;
  localparam logic [7:0] STATUS_MATCH    = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'h02;
  localparam logic [7:0] STATUS_BAD_LEN  = 8'h03;

  localparam int HDR_BYTES             = 20;
  localparam int MAX_STR_BYTES_DEFAULT = 55;

  // Whole bytes only, at least one, and small enough for a single MD5 block.
  function automatic logic str_len_legal(input logic [15:0] len_bits, input int max_bytes);
    logic [12:0] nbytes;
    nbytes = len_bits[15:3];
    return (len_bits[2:0] == 3'd0) && (nbytes != 13'd0) && ({19'd0, nbytes} <= max_bytes);
  endfunction

endpackage

// File: rtl/string_batch_resp.sv
// Response serializer: status, byte_pos hi/lo, then the matched string pulled from the processor.
module string_batch_resp
  import string_batch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  status,
  input  logic [15:0] byte_pos,
  input  logic [12:0] num_chars,
  input  logic [7:0]  match_char,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        char_next,
  output logic        done
);

  typedef enum logic [1:0] {R_STATUS, R_POS_HI, R_POS_LO, R_CHAR} ridx_e;

  ridx_e       idx_q, idx_d;
  logic [12:0] chars_left_q, chars_left_d;
  logic [15:0] pos_q, pos_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        fetch_q, fetch_d;
  logic        accept;

  assign accept = tx_valid_q && tx_ready;

  always_comb begin
    idx_d        = idx_q;
    chars_left_d = chars_left_q;
    pos_d        = pos_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    fetch_d      = 1'b0;
    char_next    = 1'b0;
    done         = 1'b0;
    if (start) begin
      idx_d        = R_STATUS;
      tx_data_d    = status;
      tx_valid_d   = 1'b1;
      pos_d        = byte_pos;
      chars_left_d = (status == STATUS_MATCH) ? num_chars : 13'd0;
    end else if (fetch_q) begin
      // The processor presents the next char one cycle after char_next.
      tx_data_d  = match_char;
      tx_valid_d = 1'b1;
    end else if (accept) begin
      unique case (idx_q)
        R_STATUS: begin
          idx_d     = R_POS_HI;
          tx_data_d = pos_q[15:8];
        end
        R_POS_HI: begin
          idx_d     = R_POS_LO;
          tx_data_d = pos_q[7:0];
        end
        R_POS_LO: begin
          if (chars_left_q != 13'd0) begin
            idx_d     = R_CHAR;
            tx_data_d = match_char;
          end else begin
            tx_valid_d = 1'b0;
            done       = 1'b1;
          end
        end
        R_CHAR: begin
          char_next    = 1'b1;
          chars_left_d = chars_left_q - 13'd1;
          tx_valid_d   = 1'b0;
          if (chars_left_q == 13'd1) done = 1'b1;
          else fetch_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q        <= R_STATUS;
      chars_left_q <= 13'd0;
      pos_q        <= 16'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      fetch_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      chars_left_q <= chars_left_d;
      pos_q        <= pos_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      fetch_q      <= fetch_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/string_batch_ctrl.sv
// Batch sequencer: parses a host frame, drives the match processor, and hands the result to the
// response serializer.
module string_batch_ctrl
  import string_batch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int MAX_STR_BYTES  = MAX_STR_BYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         proc_start,
  output logic [15:0]  proc_num_bytes,
  output logic [127:0] proc_target_hash,
  output logic [15:0]  proc_str_len,
  output logic [7:0]   proc_data,
  output logic         proc_data_valid,
  output logic         proc_match_char_next,
  input  logic         proc_done,
  input  logic         proc_match,
  input  logic [15:0]  proc_byte_pos,
  input  logic [7:0]   proc_match_char,
  output logic         busy
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [4:0]      HDR_LAST = 5'(HDR_BYTES - 1);

  state_e          state_q, state_d;
  logic [4:0]      hdr_cnt_q, hdr_cnt_d;
  logic [127:0]    hash_q, hash_d;
  logic [15:0]     str_len_q, str_len_d;
  logic [15:0]     num_bytes_q, num_bytes_d;
  logic [15:0]     rem_q, rem_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      settle_q, settle_d;
  logic [7:0]      proc_data_q, proc_data_d;
  logic            proc_data_valid_q, proc_data_valid_d;
  logic            proc_start_q, proc_start_d;
  logic            rx_ready_q, rx_ready_d;
  logic            busy_q, busy_d;
  logic            rx_accept, resp_start, resp_done;
  logic [7:0]      resp_status;
  logic [15:0]     resp_pos;

  assign rx_accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d           = state_q;
    hdr_cnt_d         = hdr_cnt_q;
    hash_d            = hash_q;
    str_len_d         = str_len_q;
    num_bytes_d       = num_bytes_q;
    rem_d             = rem_q;
    to_cnt_d          = to_cnt_q;
    settle_d          = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    proc_data_d       = proc_data_q;
    proc_data_valid_d = 1'b0;
    resp_start        = 1'b0;
    resp_status       = STATUS_NO_MATCH;
    resp_pos          = 16'd0;
    case (state_q)
      S_IDLE: if (rx_accept) begin
        hash_d    = {hash_q[119:0], rx_data};
        hdr_cnt_d = 5'd1;
        state_d   = S_HDR;
      end
      S_HDR: if (rx_accept) begin
        hdr_cnt_d = hdr_cnt_q + 5'd1;
        if (hdr_cnt_q < 5'd16)      hash_d      = {hash_q[119:0], rx_data};
        else if (hdr_cnt_q < 5'd18) str_len_d   = {str_len_q[7:0], rx_data};
        else                        num_bytes_d = {num_bytes_q[7:0], rx_data};
        if (hdr_cnt_q == HDR_LAST) begin
          if (str_len_legal(str_len_q, MAX_STR_BYTES)) begin
            state_d = S_START;
          end else begin
            state_d = S_DRAIN;
            rem_d   = num_bytes_d;
          end
        end
      end
      S_START: begin
        rem_d    = num_bytes_q;
        to_cnt_d = '0;
        settle_d = 2'd0;
        state_d  = (num_bytes_q == 16'd0) ? S_WAIT_DONE : S_STREAM;
      end
      S_STREAM: if (rx_accept) begin
        proc_data_d       = rx_data;
        proc_data_valid_d = 1'b1;
        rem_d             = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = S_WAIT_DONE;
      end
      S_DRAIN: begin
        if (rem_q == 16'd0) begin
          resp_start  = 1'b1;
          resp_status = STATUS_BAD_LEN;
          state_d     = S_RESP;
        end else if (rx_accept) begin
          rem_d = rem_q - 16'd1;
        end
      end
      S_WAIT_DONE: begin
        // proc_done is stale for two cycles after the start pulse.
        if (settle_q == 2'd2 && proc_done) begin
          resp_start  = 1'b1;
          resp_status = proc_match ? STATUS_MATCH : STATUS_NO_MATCH;
          resp_pos    = proc_match ? proc_byte_pos : 16'd0;
          state_d     = S_RESP;
        end else if (to_cnt_q >= TO_LAST) begin
          resp_start  = 1'b1;
          resp_status = STATUS_TIMEOUT;
          state_d     = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      S_RESP: if (resp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    proc_start_d = (state_d == S_START);
    case (state_d)
      S_IDLE, S_HDR:     rx_ready_d = 1'b1;
      S_STREAM, S_DRAIN: rx_ready_d = (rem_d != 16'd0);
      default:           rx_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      hdr_cnt_q         <= 5'd0;
      hash_q            <= 128'd0;
      str_len_q         <= 16'd0;
      num_bytes_q       <= 16'd0;
      rem_q             <= 16'd0;
      to_cnt_q          <= '0;
      settle_q          <= 2'd0;
      proc_data_q       <= 8'd0;
      proc_data_valid_q <= 1'b0;
      proc_start_q      <= 1'b0;
      rx_ready_q        <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      hdr_cnt_q         <= hdr_cnt_d;
      hash_q            <= hash_d;
      str_len_q         <= str_len_d;
      num_bytes_q       <= num_bytes_d;
      rem_q             <= rem_d;
      to_cnt_q          <= to_cnt_d;
      settle_q          <= settle_d;
      proc_data_q       <= proc_data_d;
      proc_data_valid_q <= proc_data_valid_d;
      proc_start_q      <= proc_start_d;
      rx_ready_q        <= rx_ready_d;
      busy_q            <= busy_d;
    end
  end

  string_batch_resp u_resp (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (resp_start),
    .status    (resp_status),
    .byte_pos  (resp_pos),
    .num_chars (str_len_q[15:3]),
    .match_char(proc_match_char),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .char_next (proc_match_char_next),
    .done      (resp_done)
  );

  assign rx_ready         = rx_ready_q;
  assign busy             = busy_q;
  assign proc_start       = proc_start_q;
  assign proc_num_bytes   = num_bytes_q;
  assign proc_target_hash = hash_q;
  assign proc_str_len     = str_len_q;
  assign proc_data        = proc_data_q;
  assign proc_data_valid  = proc_data_valid_q;

endmodule

// File: tb/tb_string_batch_ctrl.sv
// Directed bench for string_batch_ctrl with a small behavioural match-processor model.
`timescale 1ns/1ps
module tb_string_batch_ctrl;

  localparam int TO_CYC = 100;
  localparam logic [127:0] HASH_AB = 128'h187ef4436122d1cc2f40dc2b92f0eba0;
  localparam int M_NOMATCH = 0;
  localparam int M_MATCH   = 1;
  localparam int M_HANG    = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         proc_start;
  logic [15:0]  proc_num_bytes;
  logic [127:0] proc_target_hash;
  logic [15:0]  proc_str_len;
  logic [7:0]   proc_data;
  logic         proc_data_valid;
  logic         proc_match_char_next;
  logic         proc_done;
  logic         proc_match;
  logic [15:0]  proc_byte_pos;
  logic [7:0]   proc_match_char;
  logic         busy;

  always #5 clk = ~clk;

  string_batch_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .proc_start          (proc_start),
    .proc_num_bytes      (proc_num_bytes),
    .proc_target_hash    (proc_target_hash),
    .proc_str_len        (proc_str_len),
    .proc_data           (proc_data),
    .proc_data_valid     (proc_data_valid),
    .proc_match_char_next(proc_match_char_next),
    .proc_done           (proc_done),
    .proc_match          (proc_match),
    .proc_byte_pos       (proc_byte_pos),
    .proc_match_char     (proc_match_char),
    .busy                (busy)
  );

  // Processor model: stale flags for 2 cycles after start, then done after done_at cycles.
  int   mode;
  int   done_at;
  logic stale_flag;
  int   mdl_cyc = 1000;
  int   char_idx = 0;
  logic stale_win;

  always @(posedge clk) begin
    if (proc_start) begin
      mdl_cyc  <= 0;
      char_idx <= 0;
    end else begin
      if (mdl_cyc < 1000) mdl_cyc <= mdl_cyc + 1;
      if (proc_match_char_next) char_idx <= char_idx + 1;
    end
  end

  assign stale_win       = (mdl_cyc < 2);
  assign proc_done       = stale_win ? stale_flag : (mode != M_HANG && mdl_cyc >= done_at);
  assign proc_match      = stale_win ? stale_flag : (mode == M_MATCH);
  assign proc_byte_pos   = stale_win ? 16'h1234 : ((mode == M_MATCH) ? 16'h0002 : 16'h0077);
  assign proc_match_char = (char_idx == 0) ? 8'h61 : ((char_idx == 1) ? 8'h62 : 8'h3f);

  int         n_start = 0;
  int         n_dv = 0;
  int         n_cn = 0;
  logic [7:0] cap [0:1023];

  always @(posedge clk) begin
    if (reset_n) begin
      if (proc_start) n_start <= n_start + 1;
      if (proc_match_char_next) n_cn <= n_cn + 1;
      if (proc_data_valid) begin
        cap[n_dv[9:0]] <= proc_data;
        n_dv <= n_dv + 1;
      end
    end
  end

  int         checks = 0;
  int         failures = 0;
  int         first_wait;
  logic [7:0] pay  [0:15];
  logic [7:0] rexp [0:7];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rx_accept", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] h, input logic [15:0] sl, input logic [15:0] nb,
                            input int n_send, input int gapmax);
    for (int i = 0; i < 16; i++) send_byte(h[127-8*i -: 8], 0);
    send_byte(sl[15:8], 0);
    send_byte(sl[7:0], 0);
    send_byte(nb[15:8], 0);
    send_byte(nb[7:0], 0);
    for (int i = 0; i < n_send; i++) send_byte(pay[i], int'($urandom_range(gapmax, 0)));
  endtask

  task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e);
    rexp[0] = a; rexp[1] = b; rexp[2] = c; rexp[3] = d; rexp[4] = e;
  endtask

  task automatic recv_resp(input string name, input int n, input int stall);
    logic [7:0] got [0:7];
    int   t;
    logic stable;
    for (int k = 0; k < n; k++) begin
      tx_ready = 1'b0;
      t = 0;
      while (!tx_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (k == 0) first_wait = t;
      check($sformatf("%s_valid%0d", name, k), tx_valid, 1'b1);
      got[k] = tx_data;
      if (k == 0 && stall > 0) begin
        stable = 1'b1;
        repeat (stall) begin
          @(negedge clk);
          if (!(tx_valid === 1'b1 && tx_data === got[0])) stable = 1'b0;
        end
        check($sformatf("%s_hold", name), stable, 1'b1);
      end
      check($sformatf("%s_byte%0d", name, k), got[k], rexp[k]);
      tx_ready = 1'b1;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check($sformatf("%s_end", name), tx_valid, 1'b0);
    $display("resp %s: status=%02h pos=%02h%02h bytes=%0d wait=%0d", name, got[0], got[1], got[2], n, first_wait);
  endtask

  int s0, d0, c0;

  task automatic snap();
    s0 = n_start;
    d0 = n_dv;
    c0 = n_cn;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    mode = M_NOMATCH; done_at = 6; stale_flag = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", proc_start, 1'b0);
    check("rst_dv", proc_data_valid, 1'b0);
    check("rst_hash", proc_target_hash, 128'd0);
    check("rst_fields", {proc_num_bytes, proc_str_len, proc_data}, 40'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rx_ready", rx_ready, 1'b1);

    // Match on "ab"
    mode = M_MATCH; done_at = 8;
    pay[0] = 8'h78; pay[1] = 8'h61; pay[2] = 8'h62;
    snap();
    send_frame(HASH_AB, 16'd16, 16'd3, 3, 0);
    check("m_hash", proc_target_hash, HASH_AB);
    check("m_str_len", proc_str_len, 16'd16);
    check("m_num_bytes", proc_num_bytes, 16'd3);
    check("m_busy", busy, 1'b1);
    set_exp(8'h01, 8'h00, 8'h02, 8'h61, 8'h62);
    recv_resp("match", 5, 0);
    check("m_char_next", n_cn - c0, 2);
    check("m_starts", n_start - s0, 1);
    check("m_dv", n_dv - d0, 3);
    for (int i = 0; i < 3; i++) check($sformatf("m_data%0d", i), cap[10'(d0 + i)], pay[i]);
    check("m_idle", busy, 1'b0);

    // No match, 5 bytes
    mode = M_NOMATCH; done_at = 8;
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h30 + i);
    snap();
    send_frame(128'h0123456789abcdef0011223344556677, 16'd40, 16'd5, 5, 0);
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    recv_resp("nomatch", 3, 0);
    check("nm_starts", n_start - s0, 1);
    check("nm_dv", n_dv - d0, 5);
    check("nm_char_next", n_cn - c0, 0);

    // Bad length (12 bits) with 4 payload bytes drained
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'hc0 + i);
    snap();
    send_frame(HASH_AB, 16'd12, 16'd4, 4, 0);
    set_exp(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
    recv_resp("badlen", 3, 0);
    check("bl_starts", n_start - s0, 0);
    check("bl_dv", n_dv - d0, 0);

    // Timeout after 100 cycles; also proves the frame after a bad length parses
    mode = M_HANG;
    pay[0] = 8'h11; pay[1] = 8'h22;
    snap();
    send_frame(HASH_AB, 16'd8, 16'd2, 2, 0);
    check("to_str_len", proc_str_len, 16'd8);
    check("to_num_bytes", proc_num_bytes, 16'd2);
    set_exp(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    recv_resp("timeout", 3, 0);
    check("to_wait", first_wait, TO_CYC);
    check("to_starts", n_start - s0, 1);

    // Backpressure: rx gaps and 10-cycle tx stall
    mode = M_MATCH; done_at = 8;
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'h90 + 3 * i);
    snap();
    send_frame(HASH_AB, 16'd16, 16'd8, 8, 3);
    set_exp(8'h01, 8'h00, 8'h02, 8'h61, 8'h62);
    recv_resp("backpress", 5, 10);
    check("bp_dv", n_dv - d0, 8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_data%0d", i), cap[10'(d0 + i)], pay[i]);
    check("bp_char_next", n_cn - c0, 2);

    // Stale done/match around start must be ignored (num_bytes = 0)
    mode = M_NOMATCH; done_at = 6; stale_flag = 1'b1;
    snap();
    send_frame(HASH_AB, 16'd16, 16'd0, 0, 0);
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    recv_resp("stale", 3, 0);
    check("st_starts", n_start - s0, 1);
    stale_flag = 1'b0;

    // Reset in the middle of STREAM, then a fresh frame
    mode = M_MATCH; done_at = 10;
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'h50 + i);
    send_frame(HASH_AB, 16'd16, 16'd6, 2, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_rx_ready", rx_ready, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_tx_valid", tx_valid, 1'b0);
    check("mr_dv", proc_data_valid, 1'b0);
    check("mr_hash", proc_target_hash, 128'd0);
    check("mr_num_bytes", proc_num_bytes, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);
    pay[0] = 8'h61; pay[1] = 8'h62; pay[2] = 8'h63;
    snap();
    send_frame(HASH_AB, 16'd16, 16'd3, 3, 1);
    set_exp(8'h01, 8'h00, 8'h02, 8'h61, 8'h62);
    recv_resp("after_rst", 5, 0);
    check("ar_dv", n_dv - d0, 3);
    check("ar_starts", n_start - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
